// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray conversions and depth, used by both pointer sides.
package fifo_pkg;

  localparam int MaxPtrW = 32;

  function automatic logic [MaxPtrW-1:0] bin2gray(
    input logic [MaxPtrW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MaxPtrW-1:0] gray2bin(
    input logic [MaxPtrW-1:0] g
  );
    logic [MaxPtrW-1:0] b;
    b = '0;
    b[MaxPtrW-1] = g[MaxPtrW-1];
    for (int i = MaxPtrW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int fifo_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the
// priority pointer wins, wrapping modulo Requesters.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int Requesters = 2,
  localparam int IW = idx_width(Requesters)
) (
  input  logic [Requesters-1:0] req_i,
  input  logic [IW-1:0]         prio_i,
  output logic [Requesters-1:0] grant_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < Requesters; i++) begin
      idx = int'(prio_i) + i;
      if (idx >= Requesters) begin
        idx = idx - Requesters;
      end
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// FIFO write-side controller: round-robin write port sharing, pointers, full.
// Optional almost_full flag under FIFO_WR_ARB_ALMOST_FULL_EN.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int Width      = 4,
  parameter int Address    = 2,
  parameter int Requesters = 2
) (
  input  logic                        w_clk,
  input  logic                        w_rst,
  input  logic [Requesters-1:0]       req,
  input  logic [Requesters*Width-1:0] req_data,
  output logic [Requesters-1:0]       grant,
  output logic                        w_en,
  output logic [Width-1:0]            w_data,
  output logic [Address:0]            w_addr,
  output logic [Address:0]            w_ptr_gray,
  input  logic [Address:0]            r_ptr_gray_sync,
  output logic                        full,
  output logic                        almost_full
);

  localparam int PW = Address + 1;
  localparam int IW = idx_width(Requesters);
  localparam logic [PW-1:0] FullMask = PW'(3) << (Address - 1);

  logic [PW-1:0]         w_addr_q, w_addr_d;
  logic [PW-1:0]         w_gray_q, w_gray_d;
  logic                  full_q, full_d;
  logic [IW-1:0]         prio_q, prio_d;
  logic [IW-1:0]         gidx;
  logic [Requesters-1:0] req_v;

  // Full or reset blocks every grant, so nothing is accepted in those cycles.
  assign req_v = req & {Requesters{~(full_q | w_rst)}};

  rr_arbiter #(
    .Requesters(Requesters)
  ) u_rr (
    .req_i  (req_v),
    .prio_i (prio_q),
    .grant_o(grant)
  );

  assign w_en = |grant;

  always_comb begin
    w_data = '0;
    gidx   = '0;
    for (int i = 0; i < Requesters; i++) begin
      if (grant[i]) begin
        w_data = w_data | req_data[i*Width +: Width];
        gidx   = IW'(i);
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (w_en) begin
      if (gidx == IW'(Requesters - 1)) begin
        prio_d = '0;
      end else begin
        prio_d = gidx + IW'(1);
      end
    end
  end

  assign w_addr_d = w_addr_q + PW'(w_en);
  assign w_gray_d = PW'(bin2gray(MaxPtrW'(w_addr_d)));
  assign full_d   = (w_gray_d == (r_ptr_gray_sync ^ FullMask));

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_addr_q <= '0;
      w_gray_q <= '0;
      full_q   <= 1'b0;
      prio_q   <= '0;
    end else begin
      w_addr_q <= w_addr_d;
      w_gray_q <= w_gray_d;
      full_q   <= full_d;
      prio_q   <= prio_d;
    end
  end

  assign w_addr     = w_addr_q;
  assign w_ptr_gray = w_gray_q;
  assign full       = full_q;

`ifdef FIFO_WR_ARB_ALMOST_FULL_EN
  logic [PW-1:0] r_bin;
  logic [PW-1:0] occ;
  logic          af_q, af_d;

  assign r_bin = PW'(gray2bin(MaxPtrW'(r_ptr_gray_sync)));
  assign occ   = w_addr_d - r_bin;
  assign af_d  = (occ >= PW'(fifo_depth(Address) - 1));

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign almost_full = af_q;
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (Width=4, Address=2, Requesters=2).
module tb_fifo_wr_arbiter;

  logic       w_clk;
  logic       w_rst;
  logic [1:0] req;
  logic [7:0] req_data;
  logic [1:0] grant;
  logic       w_en;
  logic [3:0] w_data;
  logic [2:0] w_addr;
  logic [2:0] w_ptr_gray;
  logic [2:0] r_ptr_gray_sync;
  logic       full;
  logic       almost_full;

  typedef struct {
    logic [1:0] g;
    logic [3:0] d;
    logic [2:0] a;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

`ifdef FIFO_WR_ARB_ALMOST_FULL_EN
  localparam logic AfOn = 1'b1;
`else
  localparam logic AfOn = 1'b0;
`endif

  fifo_wr_arbiter #(
    .Width(4), .Address(2), .Requesters(2)
  ) dut (
    .w_clk          (w_clk),
    .w_rst          (w_rst),
    .req            (req),
    .req_data       (req_data),
    .grant          (grant),
    .w_en           (w_en),
    .w_data         (w_data),
    .w_addr         (w_addr),
    .w_ptr_gray     (w_ptr_gray),
    .r_ptr_gray_sync(r_ptr_gray_sync),
    .full           (full),
    .almost_full    (almost_full)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [3:0] d,
                      input logic [2:0] a);
    exp_t e;
    e.g = g;
    e.d = d;
    e.a = a;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge w_clk);
      if (w_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: grant=%b data=%h addr=%0d",
                   grant, w_data, w_addr);
        end else begin
          e = sb.pop_front();
          if (grant !== e.g || w_data !== e.d || w_addr !== e.a) begin
            errors++;
            $display("FAIL write: got g=%b d=%h a=%0d exp g=%b d=%h a=%0d",
                     grant, w_data, w_addr, e.g, e.d, e.a);
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    w_rst           = 1'b1;
    req             = 2'b00;
    req_data        = 8'h00;
    r_ptr_gray_sync = 3'b000;
    fork
      monitor();
    join_none
    repeat (2) cyc();
    req = 2'b11;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_addr", 32'(w_addr), 32'h0);
    chk("rst_gray", 32'(w_ptr_gray), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_af", 32'(almost_full), 32'h0);
    req = 2'b00;
    cyc();
    w_rst = 1'b0;
    cyc();

    // fill: alternating grants, data 3 then 5
    req_data = {4'h5, 4'h3};
    push(2'b01, 4'h3, 3'd0);
    push(2'b10, 4'h5, 3'd1);
    push(2'b01, 4'h3, 3'd2);
    push(2'b10, 4'h5, 3'd3);
    req = 2'b11;
    repeat (3) cyc();
    chk("fill3_full", 32'(full), 32'h0);
    chk("fill3_af", 32'(almost_full), 32'(AfOn));
    cyc();
    chk("fill4_full", 32'(full), 32'h1);
    chk("fill4_addr", 32'(w_addr), 32'h4);
    chk("fill4_gray", 32'(w_ptr_gray), 32'h6);
    chk("fill4_grant", 32'(grant), 32'h0);
    cyc();
    chk("hold_addr", 32'(w_addr), 32'h4);
    chk("hold_full", 32'(full), 32'h1);

    // read pointer advances to 2
    push(2'b01, 4'h3, 3'd4);
    push(2'b10, 4'h5, 3'd5);
    r_ptr_gray_sync = 3'b011;
    cyc();
    chk("drain_full", 32'(full), 32'h0);
    repeat (2) cyc();
    chk("refill_full", 32'(full), 32'h1);
    chk("refill_addr", 32'(w_addr), 32'h6);
    chk("refill_gray", 32'(w_ptr_gray), 32'h5);
    chk("refill_grant", 32'(grant), 32'h0);

    // empty again, only requester 1, pointer wraps 7->0
    push(2'b10, 4'hA, 3'd6);
    push(2'b10, 4'hA, 3'd7);
    push(2'b10, 4'hA, 3'd0);
    req_data        = {4'hA, 4'h0};
    req             = 2'b10;
    r_ptr_gray_sync = 3'b101;
    cyc();
    chk("r1_full", 32'(full), 32'h0);
    repeat (3) cyc();
    req = 2'b00;
    chk("wrap_addr", 32'(w_addr), 32'h1);
    chk("wrap_gray", 32'(w_ptr_gray), 32'h1);
    chk("wrap_af", 32'(almost_full), 32'(AfOn));
    cyc();

    // reset mid-operation after two writes
    push(2'b01, 4'h3, 3'd1);
    push(2'b10, 4'h5, 3'd2);
    req_data        = {4'h5, 4'h3};
    req             = 2'b11;
    r_ptr_gray_sync = 3'b001;
    repeat (2) cyc();
    chk("pre_rst_addr", 32'(w_addr), 32'h3);
    #1;
    w_rst = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_addr", 32'(w_addr), 32'h0);
    chk("mid_rst_full", 32'(full), 32'h0);
    chk("mid_rst_gray", 32'(w_ptr_gray), 32'h0);
    r_ptr_gray_sync = 3'b000;
    push(2'b01, 4'h3, 3'd0);
    cyc();
    w_rst = 1'b0;
    cyc();
    req = 2'b00;
    repeat (2) cyc();
    chk("post_rst_addr", 32'(w_addr), 32'h1);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Write-side controller for the asynchronous FIFO storage array.
- Shares the single FIFO write port between `Requesters` producers using round-robin arbitration.
- Owns the binary/Gray write pointer and generates the registered `full` flag from an already-synchronised read Gray pointer.
- Drives the storage array's `w_en`, `w_data` and `w_addr` directly, in the `w_clk` domain.

## Interface
- `Width`, 4: data word width.
- `Address`, 2: address bits; FIFO depth is 2**Address.
- `Requesters`, 2: number of producers, at least 1.

Ports:
- `w_clk` in 1: write clock; the only clock.
- `w_rst` in 1: reset, asynchronous, active-high.
- `req` in Requesters: per-producer write request, held until granted.
- `req_data` in Requesters*Width: producer i's data sits at bits [i*Width +: Width].
- `grant` out Requesters: one-hot accept, combinational.
- `w_en` out 1: storage write enable, equal to OR of `grant`.
- `w_data` out Width: `req_data` slice of the granted producer; 0 when no grant.
- `w_addr` out Address+1: binary write pointer; MSB is the wrap bit.
- `w_ptr_gray` out Address+1: Gray write pointer, registered, for the read-side synchroniser.
- `r_ptr_gray_sync` in Address+1: read Gray pointer, already synchronised into `w_clk`.
- `full` out 1: FIFO full, registered.
- `almost_full` out 1: one or fewer free entries; see Configuration.

## Operation
- Reset values: `w_addr`=0, `w_ptr_gray`=0, `full`=0, `almost_full`=0, priority pointer=0.
- Grant rule:
  - When `full`=0 and any `req` is high, grant exactly one requester: the first requesting index at or after the priority pointer, wrapping modulo `Requesters`.
  - When `full`=1, `grant`=0 regardless of `req`.
- Handshake: a request is accepted at the `w_clk` edge where its `grant` bit is high. The producer holds `req`/data stable until that edge and may drop or change them afterwards.
- On an accepted write:
  - `w_addr` increments by 1, modulo 2**(Address+1).
  - `w_ptr_gray` = bin2gray(new `w_addr`).
  - Priority pointer = granted index + 1, modulo `Requesters`.
- With no grant, the pointers and the priority pointer hold.
- Full computation:
  - full_next = (bin2gray(w_addr_next) == {~r_ptr_gray_sync[Address:Address-1], r_ptr_gray_sync[Address-2:0]}).
  - For Address=1, the low slice is empty.
  - `full` registers full_next every cycle.
- Wrap-around: the pointer overflows from 2**(Address+1)-1 to 0 with no special handling.
- `Requesters`=1: the arbiter reduces to grant = req & ~full.
- Reset asserted mid-operation:
  - All registers return to their reset values immediately.
  - Any write in flight is dropped.
  - `grant` is 0 while `w_rst`=1.

## Timing
- `grant`, `w_en`, `w_data`: combinational, same cycle as `req`, zero latency.
- `w_addr` and `w_ptr_gray` update one edge after the accept. `w_addr` is stable during the write cycle, so the storage array writes at the current `w_addr`.
- Full assertion:
  - `full` rises at the same edge that accepts the last free entry.
  - No further grant is issued in the following cycle.
- Full deassertion: `full` falls one `w_clk` edge after `r_ptr_gray_sync` changes. Synchroniser latency, external to this block, adds to this.
- Throughput: one write per cycle while not full.

## Configuration
- Macro: `FIFO_WR_ARB_ALMOST_FULL_EN`.
- Defined:
  - occupancy = w_addr_next - gray2bin(r_ptr_gray_sync), computed modulo 2**(Address+1).
  - `almost_full` registers (occupancy >= 2**Address - 1).
  - Reset value 0.
- Undefined: `almost_full` is tied to 0 and no gray2bin logic is built.

## Structure
- Shared package `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions.
  - Depth constant 2**Address.
  - These are reused by the read-side controller.
- One sub-module: `rr_arbiter`.
  - Request vector plus priority pointer in, one-hot grant out.
  - Combinational, parameterised by `Requesters`.

## Test plan
All scenarios use Width=4, Address=2, Requesters=2.
1. Reset, then both `req`=1 with `r_ptr_gray_sync`=000:
   - Grants go 01, 10, 01, 10.
   - `w_addr` goes 0, 1, 2, 3, 4.
   - After the 4th write, `full`=1 and `w_ptr_gray`=110; the next cycle has `grant`=00.
2. From scenario 1's full state, set `r_ptr_gray_sync`=011 (read ptr 2):
   - `full`=0 one cycle later.
   - Exactly two more grants follow, then `full`=1 with `w_addr`=6 (`w_ptr_gray`=101).
3. Only `req[1]`=1, data 4'hA:
   - `grant`=10 every cycle; `w_data`=4'hA.
   - The priority pointer does not starve requester 1.
4. Both requesting, `req_data`={4'h5, 4'h3}:
   - First `w_data`=4'h3, then 4'h5.
   - The grant sequence alternates starting from index 0 after reset.
5. With `FIFO_WR_ARB_ALMOST_FULL_EN` and `r_ptr_gray_sync`=000: `almost_full`=1 after the 3rd write and `full`=0 until the 4th.
6. Assert `w_rst` after 2 writes, mid-cycle with `req` high:
   - Immediately: `grant`=00, `w_addr`=0, `full`=0.
   - After release, the first grant goes to index 0.
